// File: rtl/serial_frame_pkg.sv
// Shared types for the serial frame receiver: FSM state encoding and default frame width.
// Nothing in here holds state; it is imported by the receiver top.
package serial_frame_pkg;

    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        STOP = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Serial line into the framer and the one-cycle frame-done pulse out of it.
// The master side drives the line; the slave side is the receiver.
interface serial_frame_receiver_if;

    logic in;
    logic done;

    modport master (
        output in,
        input  done
    );

    modport slave (
        input  in,
        output done
    );

endinterface

// File: rtl/serial_bit_counter.sv
// Data-bit position counter for the framer; last flags the final data bit of a frame.
// Registered count, last is a decode of the register; no backpressure.
module serial_bit_counter #(
    parameter int DATA_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST_VAL = CW'(DATA_BITS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == LAST_VAL);

endmodule

// File: rtl/serial_frame_receiver.sv
// Start/data/stop framer on a synchronised serial line; done pulses for one cycle per good frame.
// done rises one cycle after the stop-bit edge; no backpressure, the line is consumed every clk.
module serial_frame_receiver
    import serial_frame_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_frame_receiver_if.slave  rx
);

    state_t state_q;
    state_t state_d;
    logic   cnt_clear;
    logic   cnt_en;
    logic   cnt_last;

    // Counter is held at zero outside DATA so every frame starts counting from bit 0.
    assign cnt_clear = (state_q != DATA);
    assign cnt_en    = (state_q == DATA);

    serial_bit_counter #(
        .DATA_BITS (DATA_BITS)
    ) u_bit_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .last   (cnt_last)
    );

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = rx.in ? IDLE : DATA;
            DATA:    state_d = cnt_last ? STOP : DATA;
            STOP:    state_d = rx.in ? DONE : ERR;
            // A low sample in DONE is the start bit of a back-to-back frame.
            DONE:    state_d = rx.in ? IDLE : DATA;
            // Stay out of framing until the line returns to idle.
            ERR:     state_d = rx.in ? IDLE : ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign rx.done = (state_q == DONE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed frame scenarios plus a random soak against an edge-indexed frame model.
module tb_serial_frame_receiver;

    localparam int DATA_BITS = 8;

    logic clk;
    logic reset;

    serial_frame_receiver_if rx_if ();

    serial_frame_receiver #(
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: edge number at which the pending frame's stop bit is sampled, or -1.
    int   m_edge    = 0;
    int   m_end     = -1;
    bit   m_blocked = 1'b0;
    logic mdl_done  = 1'b0;

    logic obs[$];
    logic exp_q[$];

    task automatic model_step(input logic i, input logic r);
        mdl_done = 1'b0;
        if (r) begin
            m_end     = -1;
            m_blocked = 1'b0;
        end else if (m_end >= 0) begin
            if (m_edge == m_end) begin
                if (i) mdl_done = 1'b1;
                else   m_blocked = 1'b1;
                m_end = -1;
            end
        end else if (m_blocked) begin
            if (i) m_blocked = 1'b0;
        end else if (!i) begin
            m_end = m_edge + DATA_BITS + 1;
        end
        m_edge++;
    endtask

    task automatic tick(input logic i, input logic r);
        @(negedge clk);
        rx_if.in = i;
        reset    = r;
        @(posedge clk);
        model_step(i, r);
        #1;
        obs.push_back(rx_if.done);
        exp_q.push_back(mdl_done);
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop);
        tick(1'b0, 1'b0);
        for (int b = 0; b < DATA_BITS; b++) tick(d[b], 1'b0);
        tick(stop, 1'b0);
    endtask

    task automatic clear_log();
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        clear_log();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        for (int k = 0; k < obs.size(); k++) begin
            n_cmp++;
            if (obs[k] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_done idx=%0d got=%b want=0", k, obs[k]);
            end
        end
    endtask

    task automatic test_single_frame();
        clear_log();
        for (int k = 0; k < 9; k++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int k = 0; k < obs.size(); k++) begin
            n_cmp++;
            if (obs[k] !== ((k == 9) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL single_frame idx=%0d got=%b want=%b", k, obs[k], (k == 9));
            end
            n_cmp++;
            if (obs[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL single_frame_model idx=%0d got=%b want=%b", k, obs[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_frame(DATA_BITS'($urandom), 1'b1);
        send_frame(DATA_BITS'($urandom), 1'b1);
        tick(1'b1, 1'b0);
        for (int k = 0; k < obs.size(); k++) begin
            n_cmp++;
            if (obs[k] !== ((k == 9 || k == 19) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL back_to_back idx=%0d got=%b want=%b", k, obs[k], (k == 9 || k == 19));
            end
        end
    endtask

    task automatic test_bad_stop();
        clear_log();
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        send_frame(DATA_BITS'($urandom), 1'b1);
        for (int k = 0; k < obs.size(); k++) begin
            n_cmp++;
            if (obs[k] !== ((k == 20) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL bad_stop idx=%0d got=%b want=%b", k, obs[k], (k == 20));
            end
        end
    endtask

    task automatic test_error_hold();
        clear_log();
        send_frame(DATA_BITS'($urandom), 1'b0);
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        send_frame(DATA_BITS'($urandom), 1'b1);
        for (int k = 0; k < obs.size(); k++) begin
            n_cmp++;
            if (obs[k] !== ((k == 40) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL error_hold idx=%0d got=%b want=%b", k, obs[k], (k == 40));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        tick(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'($urandom_range(1)), 1'b0);
        tick(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
        send_frame(DATA_BITS'($urandom), 1'b1);
        for (int k = 0; k < obs.size(); k++) begin
            n_cmp++;
            if (obs[k] !== ((k == 20) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL reset_mid_frame idx=%0d got=%b want=%b", k, obs[k], (k == 20));
            end
        end
    endtask

    task automatic test_random_soak();
        int pulses;
        clear_log();
        for (int k = 0; k < 800; k++) begin
            tick(1'($urandom_range(1)), ($urandom_range(31) == 0) ? 1'b1 : 1'b0);
        end
        pulses = 0;
        for (int k = 0; k < obs.size(); k++) begin
            n_cmp++;
            if (obs[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL soak idx=%0d got=%b want=%b", k, obs[k], exp_q[k]);
            end
            if (exp_q[k] === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses == 0) begin
            n_err++;
            $display("FAIL soak_activity got=%0d pulses want=>0", pulses);
        end
    endtask

    initial begin
        rx_if.in = 1'b1;
        reset    = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_bad_stop();
        test_error_hold();
        test_reset_mid_frame();
        test_random_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
